zap_ram_pipe: RTL and testbench
===============================

# zap_ram_pipe

Parametrised pipelined single-write/single-read SRAM macro with configurable read latency, byte-enable writes and full write-to-read forwarding across every pipeline stage. Successor to the fixed 3-cycle simple RAM used in ZAP caches/TLBs. Adds a read-valid/tag handshake, synchronous reset of the pipeline and partial-word writes. Sits between cache/TLB controllers and the inferred block RAM.

## Interface
- WIDTH, 32: data width in bits; must be a multiple of 8 (elaboration error otherwise).
- DEPTH, 32: number of words; must be ≥ 2.
- LATENCY, 3: read latency in cycles; must be ≥ 1.
- TAG_WIDTH, 1: width of the read tag carried alongside each read.
- i_clk  input  1  clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_clken  input  1  global clock enable; 0 freezes all state, including the array.
- i_wr_en  input  1  write request.
- i_wr_ben  input  WIDTH/8  byte enables; bit k covers data[8k+7:8k].
- i_wr_addr  input  $clog2(DEPTH)  write address.
- i_wr_data  input  WIDTH  write data.
- i_rd_en  input  1  read request.
- i_rd_addr  input  $clog2(DEPTH)  read address.
- i_rd_tag  input  TAG_WIDTH  opaque tag returned with the data.
- o_rd_valid  output  1  read data valid.
- o_rd_tag  output  TAG_WIDTH  tag of the returned read.
- o_rd_data  output  WIDTH  read data.

## Operation
- Effective write: i_clken & ~i_reset & i_wr_en & |i_wr_ben. Only enabled bytes of mem[i_wr_addr] are updated. Bytes with ben=0 are untouched.
- Array is read-first. Stage 1 registers mem[i_rd_addr], rd_addr, tag, and valid = i_rd_en.
- Pipeline has LATENCY stages; stage LATENCY drives o_rd_*. Each stage holds {valid, addr, tag, data}.
- Forwarding: on every effective write, each stage whose addr == i_wr_addr gets the enabled bytes overwritten with i_wr_data while advancing. This applies to stage 1's load and to every stage-to-stage move. Matching ignores the valid bit.
- Result: a read sampled at edge N returns the array contents including all effective writes sampled at edges N … N+LATENCY−1, byte-exact.
- Multiple writes to the same address within the window: the latest write wins per byte.
- i_rd_en=0 still advances the pipeline. A bubble (valid=0) propagates, and o_rd_data is don't-care-but-deterministic.
- i_clken=0: no stage, array or output changes; the read in flight is held.
- Reset: all stage valids and o_rd_valid → 0, o_rd_tag → 0, o_rd_data → 0. Reset takes priority over i_clken. Array contents are not reset. Writes and reads presented during reset are dropped.

## Timing
- LATENCY register stages from i_rd_addr to o_rd_data, with no combinational path to outputs.
- Throughput: one read and one write per enabled cycle, to any addresses, including the same one.
- Same-cycle write and read to the same address: the read returns the new bytes merged over the old word.
- LATENCY=1: the single stage is the RAM read register with merge; o_rd_valid follows i_rd_en by 1 cycle.
- Reset mid-operation: in-flight reads are discarded, with no valid output afterwards. The first post-reset read returns valid exactly LATENCY enabled cycles later.
- The forwarding compare is one address comparator per stage against the current write; the critical path is compare + byte mux + register.

## Structure
- Package zap_ram_pkg: BYTE_W = 8 constant, and an elaboration-check macro for WIDTH%8, DEPTH≥2, LATENCY≥1.
- Sub-module zap_ram_fwd_stage: one stage register with address compare and byte-merge. It is instantiated LATENCY−1 times by generate after the array-read stage.
- The array and stage 1 stay in zap_ram_pipe so block-RAM inference is preserved.

## Test plan
Configuration for all scenarios: WIDTH=32, DEPTH=16, LATENCY=3.
- **Plain read:** write 0xDEADBEEF to addr 5, then idle 3 cycles, then read addr 5 with tag 1. Required response: o_rd_valid=1 and data 0xDEADBEEF exactly 3 cycles after the read, with o_rd_tag=1.
- **Forwarding in each stage:** addr 7 holds 0x11111111. Read addr 7, and in the same cycle write 0xAAAAAAAA. Repeat with the write at +1 and at +2 cycles. Required response: each read returns 0xAAAAAAAA.
- **Byte merge and latest-wins:** addr 3 holds 0x00000000. Read 3, then write ben=0001 data 0x000000AA at +0, ben=0100 data 0x00BB0000 at +1, ben=0001 data 0x000000CC at +2. Required response: 0x00BB00CC.
- **Clock-enable stall:** issue a read of addr 2 holding 0x12345678, drop i_clken for 4 cycles mid-flight with i_wr_en=1 to addr 2, then resume. Required response: the stalled write has no effect, and data 0x12345678 appears after 3 enabled cycles.
- **Reset mid-flight:** issue reads on back-to-back cycles, assert i_reset for 1 cycle after the second read. Required response: no o_rd_valid pulse; all outputs read 0 after reset; the array keeps its prior contents on the next read.
- **Back-to-back stream:** 16 consecutive reads of addrs 0–15 interleaved with writes to addr (i+1)%16. Required response: every result matches the scoreboard model, with one valid per cycle.

Source files
------------

// File: rtl/zap_ram_pkg.sv
// Shared constants, types and the parameter sanity check for the pipelined ZAP RAM.
// The check macro is expanded at module scope by every block that takes the RAM geometry.
`ifndef ZAP_RAM_PKG_SV
`define ZAP_RAM_PKG_SV

`define ZAP_RAM_CHECK_PARAMS(W, D, L) \
  if (((W) % 8) != 0) begin : g_bad_width \
    $error("zap_ram: WIDTH must be a multiple of 8"); \
  end \
  if ((D) < 2) begin : g_bad_depth \
    $error("zap_ram: DEPTH must be at least 2"); \
  end \
  if ((L) < 1) begin : g_bad_latency \
    $error("zap_ram: LATENCY must be at least 1"); \
  end

package zap_ram_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  function automatic int num_bytes(input int width);
    return width / BYTE_W;
  endfunction

endpackage

`endif

// File: rtl/zap_ram_fwd_stage.sv
// One read-pipeline stage: registers {valid, addr, tag, data} and folds in the
// enabled bytes of the current write when the carried address matches it.
module zap_ram_fwd_stage
  import zap_ram_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int AW        = 5,
  parameter int TAG_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clken,
  input  logic                 wr_fire,
  input  logic [WIDTH/8-1:0]   wr_ben,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 in_valid,
  input  logic [AW-1:0]        in_addr,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  output logic [AW-1:0]        out_addr,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [WIDTH-1:0]     out_data
);

  localparam int NB = num_bytes(WIDTH);

  logic             hit;
  logic [WIDTH-1:0] merged;

  // Address match ignores in_valid so bubbles stay deterministic too.
  assign hit = wr_fire && (in_addr == wr_addr);

  always_comb begin
    merged = in_data;
    for (int k = 0; k < NB; k++) begin
      if (hit && wr_ben[k]) begin
        merged[k*BYTE_W +: BYTE_W] = wr_data[k*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (clken) begin
      out_valid <= in_valid;
      out_addr  <= in_addr;
      out_tag   <= in_tag;
      out_data  <= merged;
    end
  end

endmodule

// File: rtl/zap_ram_pipe.sv
// Pipelined 1W/1R RAM with byte-enable writes and write-to-read forwarding in
// every stage. The array and the first (array-read) stage live here for RAM inference.
module zap_ram_pipe
  import zap_ram_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int LATENCY   = 3,
  parameter int TAG_WIDTH = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clken,
  input  logic                     i_wr_en,
  input  logic [WIDTH/8-1:0]       i_wr_ben,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  input  logic [TAG_WIDTH-1:0]     i_rd_tag,
  output logic                     o_rd_valid,
  output logic [TAG_WIDTH-1:0]     o_rd_tag,
  output logic [WIDTH-1:0]         o_rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = num_bytes(WIDTH);

  `ZAP_RAM_CHECK_PARAMS(WIDTH, DEPTH, LATENCY)

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_fire;
  logic             s1_hit;
  logic [WIDTH-1:0] s1_merged;

  logic                 s1_valid;
  logic [AW-1:0]        s1_addr;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [WIDTH-1:0]     s1_data;

  // ch_*[k] is the output of stage k+1; ch_*[LATENCY-1] drives the ports.
  logic                 ch_valid [LATENCY];
  logic [AW-1:0]        ch_addr  [LATENCY];
  logic [TAG_WIDTH-1:0] ch_tag   [LATENCY];
  logic [WIDTH-1:0]     ch_data  [LATENCY];

  assign wr_fire = i_clken && !i_reset && i_wr_en && (|i_wr_ben);

  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_ben[k]) begin
          mem[i_wr_addr][k*BYTE_W +: BYTE_W] <= i_wr_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read-first: mem[] here is the pre-write word, so a same-edge write is merged in explicitly.
  assign s1_hit = wr_fire && (i_rd_addr == i_wr_addr);

  always_comb begin
    s1_merged = mem[i_rd_addr];
    for (int k = 0; k < NB; k++) begin
      if (s1_hit && i_wr_ben[k]) begin
        s1_merged[k*BYTE_W +: BYTE_W] = i_wr_data[k*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_tag   <= '0;
      s1_data  <= '0;
    end else if (i_clken) begin
      s1_valid <= i_rd_en;
      s1_addr  <= i_rd_addr;
      s1_tag   <= i_rd_tag;
      s1_data  <= s1_merged;
    end
  end

  assign ch_valid[0] = s1_valid;
  assign ch_addr[0]  = s1_addr;
  assign ch_tag[0]   = s1_tag;
  assign ch_data[0]  = s1_data;

  for (genvar g = 1; g < LATENCY; g++) begin : g_stage
    zap_ram_fwd_stage #(
      .WIDTH     (WIDTH),
      .AW        (AW),
      .TAG_WIDTH (TAG_WIDTH)
    ) u_stage (
      .clk       (i_clk),
      .reset     (i_reset),
      .clken     (i_clken),
      .wr_fire   (wr_fire),
      .wr_ben    (i_wr_ben),
      .wr_addr   (i_wr_addr),
      .wr_data   (i_wr_data),
      .in_valid  (ch_valid[g-1]),
      .in_addr   (ch_addr[g-1]),
      .in_tag    (ch_tag[g-1]),
      .in_data   (ch_data[g-1]),
      .out_valid (ch_valid[g]),
      .out_addr  (ch_addr[g]),
      .out_tag   (ch_tag[g]),
      .out_data  (ch_data[g])
    );
  end

  assign o_rd_valid = ch_valid[LATENCY-1];
  assign o_rd_tag   = ch_tag[LATENCY-1];
  assign o_rd_data  = ch_data[LATENCY-1];

endmodule

// File: tb/tb_zap_ram_pipe.sv
// Scoreboard bench for zap_ram_pipe (WIDTH=32, DEPTH=16, LATENCY=3, 4-bit tags).
// Expected data is the model array at the edge the read completes, matching the forwarding window.
module tb_zap_ram_pipe;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int L  = 3;
  localparam int TW = 4;

  logic          clk;
  logic          reset;
  logic          clken;
  logic          wr_en;
  logic [3:0]    wr_ben;
  logic [3:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [3:0]    rd_addr;
  logic [TW-1:0] rd_tag;
  logic          rd_valid;
  logic [TW-1:0] rd_tag_o;
  logic [W-1:0]  rd_data;

  zap_ram_pipe #(
    .WIDTH     (W),
    .DEPTH     (D),
    .LATENCY   (L),
    .TAG_WIDTH (TW)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_clken    (clken),
    .i_wr_en    (wr_en),
    .i_wr_ben   (wr_ben),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .i_rd_tag   (rd_tag),
    .o_rd_valid (rd_valid),
    .o_rd_tag   (rd_tag_o),
    .o_rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [3:0]    addr;
    int            due;
    bit            has_want;
    logic [W-1:0]  want;
  } rd_t;

  rd_t          sb[$];
  logic [W-1:0] mdl [D];
  int           ecnt;
  int           errors;
  int           checks;
  bit           pend_has;
  logic [W-1:0] pend_want;

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] seed(input int a);
    return 32'hC0DE0000 ^ (a * 32'h01010101);
  endfunction

  task automatic check_out();
    bit  exp_v;
    rd_t r;
    exp_v = (sb.size() > 0) && (sb[0].due == ecnt);
    chk("valid", {31'd0, rd_valid}, {31'd0, exp_v});
    if (exp_v) begin
      r = sb.pop_front();
      chk("tag", {28'd0, rd_tag_o}, {28'd0, r.tag});
      chk("data", rd_data, mdl[r.addr]);
      if (r.has_want) chk("want", rd_data, r.want);
    end
  endtask

  // One clock: model update at the edge, output checks on the following falling edge.
  task automatic step();
    logic          pv;
    logic [TW-1:0] pt;
    logic [W-1:0]  pd;
    rd_t           r;
    pv = rd_valid;
    pt = rd_tag_o;
    pd = rd_data;
    @(posedge clk);
    if (reset) begin
      sb.delete();
    end else if (clken) begin
      if (wr_en) begin
        for (int k = 0; k < 4; k++)
          if (wr_ben[k]) mdl[wr_addr][k*8 +: 8] = wr_data[k*8 +: 8];
      end
      ecnt++;
      if (rd_en) begin
        r.tag = rd_tag;
        r.addr = rd_addr;
        r.due = ecnt + L - 1;
        r.has_want = pend_has;
        r.want = pend_want;
        sb.push_back(r);
        pend_has = 1'b0;
      end
    end
    @(negedge clk);
    if (reset) begin
      chk("rst_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_tag", {28'd0, rd_tag_o}, 32'd0);
      chk("rst_data", rd_data, 32'd0);
    end else if (clken) begin
      check_out();
    end else begin
      chk("hold_valid", {31'd0, rd_valid}, {31'd0, pv});
      chk("hold_tag", {28'd0, rd_tag_o}, {28'd0, pt});
      chk("hold_data", rd_data, pd);
    end
  endtask

  task automatic cyc(input bit we, input logic [3:0] wb, input logic [3:0] wa,
                     input logic [W-1:0] wd, input bit re, input logic [3:0] ra,
                     input logic [TW-1:0] rt);
    wr_en = we; wr_ben = wb; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; rd_tag = rt;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 4'h0, '0, 1'b0, 4'h0, '0);
  endtask

  task automatic want(input logic [W-1:0] v);
    pend_has = 1'b1;
    pend_want = v;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0; checks = 0; ecnt = 0; pend_has = 1'b0; pend_want = '0;
    reset = 1'b1; clken = 1'b1;
    cyc(1'b1, 4'hF, 4'd5, 32'hFFFF_FFFF, 1'b1, 4'd5, 4'd3);
    reset = 1'b0;

    for (int a = 0; a < D; a++) cyc(1'b1, 4'hF, a[3:0], seed(a), 1'b0, 4'd0, '0);

    // Plain read
    cyc(1'b1, 4'hF, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd0, '0);
    idle(3);
    want(32'hDEAD_BEEF);
    cyc(1'b0, 4'h0, 4'd0, '0, 1'b1, 4'd5, 4'd1);
    idle(3);

    // Forwarding into stage 1, 2, 3
    for (int d = 0; d < L; d++) begin
      cyc(1'b1, 4'hF, 4'd7, 32'h1111_1111, 1'b0, 4'd0, '0);
      idle(1);
      want(32'hAAAA_AAAA);
      for (int j = 0; j < L; j++)
        cyc(j == d, 4'hF, 4'd7, 32'hAAAA_AAAA, j == 0, 4'd7, d[TW-1:0]);
      idle(2);
    end

    // Byte merge, latest wins
    cyc(1'b1, 4'hF, 4'd3, 32'h0, 1'b0, 4'd0, '0);
    idle(1);
    want(32'h00BB_00CC);
    cyc(1'b1, 4'b0001, 4'd3, 32'h0000_00AA, 1'b1, 4'd3, 4'd5);
    cyc(1'b1, 4'b0100, 4'd3, 32'h00BB_0000, 1'b0, 4'd0, '0);
    cyc(1'b1, 4'b0001, 4'd3, 32'h0000_00CC, 1'b0, 4'd0, '0);
    idle(3);

    // Clock-enable stall with a blocked write and a blocked read
    cyc(1'b1, 4'hF, 4'd2, 32'h1234_5678, 1'b0, 4'd0, '0);
    idle(1);
    want(32'h1234_5678);
    cyc(1'b0, 4'h0, 4'd0, '0, 1'b1, 4'd2, 4'd6);
    idle(1);
    clken = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'hF, 4'd2, 32'hFFFF_FFFF, 1'b1, 4'd2, 4'd9);
    clken = 1'b1;
    idle(3);
    want(32'h1234_5678);
    cyc(1'b0, 4'h0, 4'd0, '0, 1'b1, 4'd2, 4'd7);
    idle(3);

    // Reset mid-flight: reads discarded, write during reset dropped
    cyc(1'b0, 4'h0, 4'd0, '0, 1'b1, 4'd1, 4'd1);
    cyc(1'b0, 4'h0, 4'd0, '0, 1'b1, 4'd2, 4'd2);
    reset = 1'b1;
    cyc(1'b1, 4'hF, 4'd4, 32'hBAD0_BAD0, 1'b1, 4'd4, 4'd8);
    reset = 1'b0;
    idle(4);
    want(seed(4));
    cyc(1'b0, 4'h0, 4'd0, '0, 1'b1, 4'd4, 4'd4);
    idle(3);

    // Back-to-back stream with interleaved writes
    for (int i = 0; i < D; i++)
      cyc(1'b1, 4'($urandom_range(0, 15)), 4'((i + 1) % D), $urandom, 1'b1, i[3:0], i[TW-1:0]);
    idle(L + 1);

    chk("drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
